// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S constants (slot width, WS polarity) and offset-binary MSB fix-up
package i2s_pkg;
  localparam int SLOT_WIDTH = 16;
  localparam logic WS_LEFT = 1'b0;
  localparam logic WS_RIGHT = 1'b1;
  function automatic logic msb_fix(input logic msb, input logic is_signed);
    return is_signed ? msb : ~msb;
  endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: BCLK divider; in clk/reset/en, out bclk plus same-clk rise/fall strobes marking the edge about to be registered
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bclk,
  output logic rise,
  output logic fall
);
  localparam int CW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  logic [CW-1:0] div_cnt;
  logic tc;
  assign tc = div_cnt == CW'(BCLK_DIV - 1);
  assign rise = !reset && en && tc && !bclk;
  assign fall = !reset && en && tc && bclk;
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div_cnt <= '0;
      bclk <= 1'b0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 1'b1;
      bclk <= bclk ^ tc;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter; in clk/reset/en/is_signed/sample_l/sample_r/sample_we, out sample_req/i2s_bclk/i2s_ws/i2s_data
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = SLOT_WIDTH,
  parameter int BCLK_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_we,
  output logic             sample_req,
  output logic             i2s_bclk,
  output logic             i2s_ws,
  output logic             i2s_data
);
  localparam int PW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0] PLAST = PW'(2 * WIDTH - 1);
  logic [WIDTH-1:0] hold_l, hold_r, next_l, next_r;
  logic [2*WIDTH-1:0] sr;
  logic [PW-1:0] p, p_next;
  logic fall, rise_unused;
  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk(clk),
    .reset(reset),
    .en(en),
    .bclk(i2s_bclk),
    .rise(rise_unused),
    .fall(fall)
  );
  // a write in the load clk bypasses straight into the shift register
  assign next_l = sample_we ? sample_l : hold_l;
  assign next_r = sample_we ? sample_r : hold_r;
  assign p_next = p == PLAST ? '0 : p + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (sample_we) begin
      hold_l <= sample_l;
      hold_r <= sample_r;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      p <= PLAST;
      sr <= '0;
      i2s_ws <= WS_LEFT;
      i2s_data <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= fall && p_next == '0;
      if (fall) begin
        p <= p_next;
        i2s_ws <= p_next >= PW'(WIDTH) ? WS_RIGHT : WS_LEFT;
        i2s_data <= sr[2*WIDTH-1];
        sr <= p_next == '0
          ? {msb_fix(next_l[WIDTH-1], is_signed), next_l[WIDTH-2:0],
             msb_fix(next_r[WIDTH-1], is_signed), next_r[WIDTH-2:0]}
          : sr << 1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx with a BCLK-rise decoder and frame scoreboard
module tb_i2s_tx;
  localparam int W = 16;
  localparam int DIV = 2;
  localparam int FRAME = 4 * W * DIV;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, is_signed = 1'b1, sample_we = 1'b0;
  logic [15:0] sample_l = '0, sample_r = '0;
  logic sample_req, i2s_bclk, i2s_ws, i2s_data;
  int checks = 0, failures = 0;
  i2s_tx #(.WIDTH(W), .BCLK_DIV(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .is_signed(is_signed),
    .sample_l(sample_l),
    .sample_r(sample_r),
    .sample_we(sample_we),
    .sample_req(sample_req),
    .i2s_bclk(i2s_bclk),
    .i2s_ws(i2s_ws),
    .i2s_data(i2s_data)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] l, r, el, er;
    logic s;
  } vec_t;
  typedef struct {
    logic [15:0] l, r;
  } pair_t;
  pair_t sb[$];
  pair_t e;
  logic [15:0] model_l = '0, model_r = '0;
  logic [15:0] acc_l = '0, acc_r = '0, last_l = '0, last_r = '0;
  logic prev_bclk = 1'b0, prev_ws = 1'b0;
  int ws_high = 0;
  function automatic logic [15:0] conv(input logic [15:0] x, input logic s);
    return s ? x : x ^ 16'h8000;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic write(input logic [15:0] l, input logic [15:0] r, input logic s);
    step();
    sample_l = l;
    sample_r = r;
    is_signed = s;
    sample_we = 1'b1;
    model_l = l;
    model_r = r;
    step();
    sample_we = 1'b0;
  endtask
  task automatic wait_req(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_req && n < 2 * FRAME);
    if (!sample_req) begin
      checks++;
      failures++;
      $display("FAIL wait_req: no sample_req within %0d clks", n);
    end
  endtask
  // decoder: sample WS/DATA on BCLK rise; each bit belongs to the channel of the previous WS
  initial begin
    forever begin
      @(negedge clk);
      if (!en) begin
        sb.delete();
        prev_ws = 1'b0;
        prev_bclk = 1'b0;
        ws_high = 0;
      end else begin
        if (i2s_bclk && !prev_bclk) begin
          if (prev_ws) acc_r = {acc_r[14:0], i2s_data};
          else acc_l = {acc_l[14:0], i2s_data};
          if (i2s_ws) ws_high++;
          if (i2s_ws && !prev_ws) last_l = acc_l;
          if (!i2s_ws && prev_ws) begin
            last_r = acc_r;
            check("ws_high_bclks", ws_high, 16);
            ws_high = 0;
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_empty: got frame %h/%h want none", last_l, last_r);
            end else begin
              e = sb.pop_front();
              check("sb_left", last_l, e.l);
              check("sb_right", last_r, e.r);
            end
          end
          prev_ws = i2s_ws;
        end
        if (sample_req) sb.push_back('{l: conv(model_l, is_signed), r: conv(model_r, is_signed)});
        prev_bclk = i2s_bclk;
      end
    end
  end
  initial begin
    vec_t tbl[4];
    int n, bad;
    tbl[0] = '{l: 16'hA5C3, r: 16'h0F01, s: 1'b1, el: 16'hA5C3, er: 16'h0F01};
    tbl[1] = '{l: 16'h8000, r: 16'hFFFF, s: 1'b0, el: 16'h0000, er: 16'h7FFF};
    tbl[2] = '{l: 16'h1234, r: 16'h8001, s: 1'b1, el: 16'h1234, er: 16'h8001};
    tbl[3] = '{l: 16'h0001, r: 16'h7FFE, s: 1'b0, el: 16'h8001, er: 16'hFFFE};
    repeat (3) step();
    check("reset_outputs", {sample_req, i2s_bclk, i2s_ws, i2s_data}, 0);
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if ({sample_req, i2s_bclk, i2s_ws, i2s_data} !== 4'b0) bad++;
    end
    check("idle_outputs_nonzero_clks", bad, 0);
    write(16'hA5C3, 16'h0F01, 1'b1);
    en = 1'b1;
    step();
    check("bclk_before_rise", i2s_bclk, 0);
    step();
    check("first_rise", i2s_bclk, 1);
    step();
    check("bclk_req_before_fall", {i2s_bclk, sample_req}, 2'b10);
    step();
    check("first_fall_req", {i2s_bclk, sample_req}, 2'b01);
    step();
    check("req_one_clk", sample_req, 0);
    for (int i = 0; i < 4; i++) begin
      write(tbl[i].l, tbl[i].r, tbl[i].s);
      wait_req(n);
      wait_req(n);
      repeat (3) step();
      check($sformatf("tbl%0d_left", i), last_l, tbl[i].el);
      check($sformatf("tbl%0d_right", i), last_r, tbl[i].er);
    end
    wait_req(n);
    for (int i = 0; i < 3; i++) begin
      wait_req(n);
      check("req_period", n, FRAME);
    end
    wait_req(n);
    repeat (126) step();
    write(16'h1234, 16'h5678, 1'b1);
    check("collide_req", sample_req, 1);
    wait_req(n);
    repeat (3) step();
    check("collide_left", last_l, 16'h1234);
    check("collide_right", last_r, 16'h5678);
    wait_req(n);
    repeat (30) step();
    check("abort_bclk_high", i2s_bclk, 1);
    en = 1'b0;
    step();
    check("abort_outputs", {sample_req, i2s_bclk, i2s_ws, i2s_data}, 0);
    bad = 0;
    repeat (9) begin
      step();
      if ({sample_req, i2s_bclk, i2s_ws, i2s_data} !== 4'b0) bad++;
    end
    check("abort_hold_nonzero_clks", bad, 0);
    en = 1'b1;
    wait_req(n);
    check("restart_req_latency", n, 2 * DIV);
    wait_req(n);
    check("restart_period", n, FRAME);
    repeat (3) step();
    check("restart_left", last_l, 16'h1234);
    check("restart_right", last_r, 16'h5678);
    en = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: serialises 16-bit left/right sample pairs onto the USER port I2S pins.
- Generates BCLK, WS and DATA itself.
- Mirror of the MT32pi I2S capture path. Lets the Menu core, or any core, drive an external DAC or loop back to the receiver.
- Sits in the CLK_AUDIO domain. At 24.576 MHz with BCLK_DIV=8 the output is 1.536 MHz BCLK, 48 kHz frames.

Parameters:
- WIDTH, 16: sample width and slot width in bits; one frame = 2*WIDTH BCLK periods.
- BCLK_DIV, 8: clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  in  1  audio clock (CLK_AUDIO); one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  transmit enable; low = synchronous soft stop.
- is_signed  in  1  1 = samples are two's complement; 0 = offset binary, MSB inverted at load.
- sample_l  in  WIDTH  left sample.
- sample_r  in  WIDTH  right sample.
- sample_we  in  1  one-clk strobe; writes sample_l/sample_r into holding registers.
- sample_req  out  1  one-clk pulse when holding registers are copied into the shift register (frame start).
- i2s_bclk  out  1  bit clock.
- i2s_ws  out  1  word select; 0 = left, 1 = right.
- i2s_data  out  1  serial data, MSB first, one-BCLK delay after WS edge (Philips I2S).

Behaviour:
- Reset, or en=0, for one clk forces on the next edge:
  - div_cnt=0, i2s_bclk=0, i2s_ws=0, i2s_data=0, sample_req=0.
  - shift register=0; frame position p=2*WIDTH-1.
- Holding registers clear only on reset. en=0 leaves them untouched.
- Divider (en=1):
  - div_cnt counts 0..BCLK_DIV-1. At terminal count it wraps and i2s_bclk toggles.
  - A toggle from 1 to 0 is a "fall event". All serial outputs update in that same clk, registered, so they change together with the BCLK falling edge.
- First toggle after enable is a rise, BCLK_DIV clks after en goes high. First fall comes BCLK_DIV clks later.
- Each fall event:
  - p <= (p==2*WIDTH-1) ? 0 : p+1.
  - i2s_ws <= (new p >= WIDTH).
  - i2s_data <= sr[2*WIDTH-1]; sr shifts left by 1.
- Frame load: on the fall event where new p==0, after the shift, sr <= {L', R'} from the holding registers, and sample_req pulses high for exactly that clk.
  - L' and R' have their MSB inverted when is_signed=0.
  - Result: p=0 carries the previous right LSB with WS low. p=1..WIDTH carry left MSB..LSB, where p=WIDTH already has WS high. p=WIDTH+1..2*WIDTH-1 carry right MSB..bit1.
- Holding-register write: sample_we=1 loads both channels in that clk, at any time.
  - If sample_we coincides with the load clk, the new values bypass into sr. That frame transmits them.
- No write for a frame: the previous pair repeats (no underflow state, no zero insertion).
- Latency:
  - Write to left MSB on i2s_data: next frame load, plus one fall event (2*BCLK_DIV clks).
  - sample_req period: 4*WIDTH*BCLK_DIV clks.
- is_signed is sampled at load time. Changing it mid-frame affects only the next frame.
- en dropping mid-frame aborts the frame; there is no drain. Re-enable always starts a fresh frame: first fall event gives p=0 plus load.
- reset has priority over en and sample_we.

Decomposition:
- Package i2s_pkg: default slot width constant (16), WS polarity constants (WS_LEFT=0, WS_RIGHT=1), and a function for offset-binary to signed MSB inversion. The future receiver refactor shares these.
- Sub-module i2s_bclk_gen (param BCLK_DIV):
  - Inputs: clk, reset, en.
  - Outputs: bclk, rise, fall strobes.
  - The serialiser consumes fall only.

Test Plan:
- Reset/idle: reset=1 for 3 clks, then en=0 for 100 clks -> i2s_bclk/ws/data/sample_req stay 0 throughout.
- Single frame, BCLK_DIV=2:
  - Stimulus: write L=16'hA5C3, R=16'h0F01, then en=1.
  - Required: first rise at clk 2, first fall at clk 4 with sample_req=1. A model sampling data on BCLK rise with one-bit delay decodes L=A5C3 (WS=0) and R=0F01 (WS=1). WS is high for exactly 16 BCLK.
- Repeat: no further writes, BCLK_DIV=2 -> sample_req every 128 clks; every frame decodes A5C3/0F01.
- Unsigned: is_signed=0, L=16'h8000, R=16'hFFFF -> decoded 16'h0000 and 16'h7FFF.
- Collision: sample_we with L=16'h1234 asserted in the same clk as sample_req -> that frame's left word decodes 1234, not the old value.
- Abort: en=0 at p=7, hold 10 clks, en=1 -> outputs 0 the clk after en falls. Next frame starts at p=0 with sample_req and retransmits the held pair intact.
